// File: rtl/step_ctrl_pkg.sv
// Shared types and helpers for the CPU step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    localparam int unsigned Rate1Hz   = 1;
    localparam int unsigned Rate10Hz  = 10;
    localparam int unsigned Rate100Hz = 100;
    localparam int unsigned Rate1kHz  = 1000;

    // Clock cycles between instruction enables for a rate select; never below one.
    function automatic int unsigned period_of(input logic [1:0] speed_sel,
                                              input int unsigned clk_hz);
        int unsigned rate;
        int unsigned period;
        case (speed_sel)
            2'd0:    rate = Rate1Hz;
            2'd1:    rate = Rate10Hz;
            2'd2:    rate = Rate100Hz;
            default: rate = Rate1kHz;
        endcase
        period = clk_hz / rate;
        return (period == 32'd0) ? 32'd1 : period;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stability counter: the output only follows
// the synchronized input after CYCLES consecutive samples at the new level.
module debouncer #(
    parameter int unsigned CYCLES = 100_000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d_in,
    output logic d_out
);

    localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_q, out_d;

    // Bring the raw asynchronous input into the clock domain.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_in};
        end
    end

    // Count samples disagreeing with the accepted level; any agreeing sample restarts the count.
    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (sync_q[1] != out_q) begin
            if (cnt_q == CntLast) begin
                out_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stability counter and accepted level.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign d_out = out_q;

endmodule

// File: rtl/step_controller.sv
// Execution controller for the 4-bit CPU: halts, free-runs at a selectable rate,
// or single-steps from a push button, issuing a one-cycle cpu_en per instruction.
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       run_sw,
    input  logic       step_btn,
    input  logic [1:0] speed_sel,
    input  logic       cpu_halt,
    output logic       cpu_en,
    output logic       running,
    output logic [7:0] step_count
);

    // Wide enough for the slowest period's terminal value, CLK_HZ - 1.
    localparam int unsigned RateW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic       run_db, step_db;
    logic       step_db_q, step_rise_q;
    logic [1:0] spd_meta_q, spd_sync_q, spd_last_q;
    logic       spd_chg;

    int unsigned period;
    logic        rate_term;

    state_e           state_q, state_d;
    logic [RateW-1:0] rate_cnt_q, rate_cnt_d;
    logic             cpu_en_q, cpu_en_d;
    logic             running_q, running_d;
    logic [7:0]       step_count_q, step_count_d;
    logic             halt_lock_q, halt_lock_d;

    debouncer #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk     (clk),
        .n_reset (n_reset),
        .d_in    (run_sw),
        .d_out   (run_db)
    );

    debouncer #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk     (clk),
        .n_reset (n_reset),
        .d_in    (step_btn),
        .d_out   (step_db)
    );

    // Rate select needs no debounce, only synchronization plus a copy to spot changes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            spd_meta_q <= 2'b00;
            spd_sync_q <= 2'b00;
            spd_last_q <= 2'b00;
        end else begin
            spd_meta_q <= speed_sel;
            spd_sync_q <= spd_meta_q;
            spd_last_q <= spd_sync_q;
        end
    end

    // Registered rising edge of the debounced step button.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            step_db_q   <= 1'b0;
            step_rise_q <= 1'b0;
        end else begin
            step_db_q   <= step_db;
            step_rise_q <= step_db & ~step_db_q;
        end
    end

    assign spd_chg   = (spd_sync_q != spd_last_q);
    assign period    = period_of(spd_sync_q, CLK_HZ);
    assign rate_term = (32'(rate_cnt_q) >= period - 32'd1);

    // FSM state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; cpu_halt outranks the run switch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALT: begin
                if (run_db && !halt_lock_q && !cpu_halt) begin
                    state_d = RUN;
                end else if (step_rise_q && !cpu_halt) begin
                    state_d = STEP;
                end
            end
            STEP:    state_d = HALT;
            RUN: begin
                if (cpu_halt || !run_db) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // Next values of the registered outputs, rate counter and halt lock.
    always_comb begin
        cpu_en_d    = 1'b0;
        running_d   = (state_d == RUN);
        halt_lock_d = halt_lock_q;
        rate_cnt_d  = '0;
        case (state_q)
            HALT: begin
                if (!run_db) begin
                    halt_lock_d = 1'b0;
                end
                cpu_en_d = (state_d == STEP);
            end
            RUN: begin
                if (cpu_halt) begin
                    halt_lock_d = 1'b1;
                end else if (run_db) begin
                    // A new rate restarts the count so the next pulse is a full new period away.
                    if (spd_chg) begin
                        rate_cnt_d = '0;
                    end else if (rate_term) begin
                        cpu_en_d   = 1'b1;
                        rate_cnt_d = '0;
                    end else begin
                        rate_cnt_d = rate_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        step_count_d = step_count_q + {7'd0, cpu_en_d};
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rate_cnt_q   <= '0;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            step_count_q <= 8'd0;
            halt_lock_q  <= 1'b0;
        end else begin
            rate_cnt_q   <= rate_cnt_d;
            cpu_en_q     <= cpu_en_d;
            running_q    <= running_d;
            step_count_q <= step_count_d;
            halt_lock_q  <= halt_lock_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = running_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller with a small clock and debounce setting.
module tb_step_controller;

    localparam int unsigned ClkHz = 1000;
    localparam int unsigned Db    = 4;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       run_sw = 1'b0;
    logic       step_btn = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic       cpu_halt = 1'b0;
    logic       cpu_en;
    logic       running;
    logic [7:0] step_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned edge_n = 0;
    int unsigned en_q[$];

    step_controller #(
        .CLK_HZ          (ClkHz),
        .DEBOUNCE_CYCLES (Db)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .speed_sel  (speed_sel),
        .cpu_halt   (cpu_halt),
        .cpu_en     (cpu_en),
        .running    (running),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Edge counter; edge_n names the most recent rising edge.
    always @(posedge clk) edge_n = edge_n + 1;

    // Record which edge produced each observed enable.
    always @(negedge clk) if (cpu_en === 1'b1) en_q.push_back(edge_n);

    // Reference: period in cycles from the rate 10**sel Hz.
    function automatic int unsigned ref_period(int unsigned sel);
        int unsigned rate = 1;
        for (int i = 0; i < int'(sel); i++) rate = rate * 10;
        return (ClkHz / rate == 0) ? 1 : ClkHz / rate;
    endfunction

    task automatic tick(int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(int unsigned e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        run_sw = 1'b0;
        step_btn = 1'b0;
        cpu_halt = 1'b0;
        speed_sel = 2'd0;
        n_reset = 1'b0;
        tick(2);
        n_reset = 1'b1;
        tick(1);
        en_q.delete();
    endtask

    task automatic test_reset;
        tick(2);
        n_reset = 1'b0;
        #2;
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", step_count); end
        tick(3);
        n_reset = 1'b1;
        en_q.delete();
        tick(Db + 10);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_idle_running: got %b want 0", running); end
        checks++; if (en_q.size() != 0) begin errors++; $display("FAIL reset_idle_pulses: got %0d want 0", en_q.size()); end
    endtask

    task automatic test_single_step;
        int unsigned e0, first;
        do_reset();
        e0 = edge_n;
        step_btn = 1'b1;
        tick(Db + 12);
        first = (en_q.size() > 0) ? en_q[0] : 0;
        checks++; if (en_q.size() != 1) begin errors++; $display("FAIL step_pulses: got %0d want 1", en_q.size()); end
        checks++; if (first != e0 + Db + 4) begin errors++; $display("FAIL step_latency: got edge %0d want %0d", first - e0, Db + 4); end
        checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL step_count: got %0d want 1", step_count); end
        step_btn = 1'b0;
        tick(Db + 6);
        checks++; if (en_q.size() != 1) begin errors++; $display("FAIL step_release: got %0d pulses want 1", en_q.size()); end
    endtask

    task automatic test_bounce;
        int unsigned e_last, first;
        do_reset();
        // Bounce with segments shorter than the debounce window, ending on a held press.
        for (int i = 0; i < 4; i++) begin
            step_btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick($urandom_range(1, Db - 1));
        end
        step_btn = 1'b1;
        e_last = edge_n;
        tick(Db + 12);
        first = (en_q.size() > 0) ? en_q[0] : 0;
        checks++; if (en_q.size() != 1) begin errors++; $display("FAIL bounce_pulses: got %0d want 1", en_q.size()); end
        checks++; if (first != e_last + Db + 4) begin errors++; $display("FAIL bounce_latency: got %0d want %0d", first, e_last + Db + 4); end
        checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL bounce_count: got %0d want 1", step_count); end
        step_btn = 1'b0;
        tick(Db + 6);
    endtask

    task automatic test_run;
        for (int iter = 0; iter < 3; iter++) begin
            int unsigned sel, per, e0, e_run, n, last, got;
            do_reset();
            sel = (iter == 0) ? 2 : $urandom_range(0, 3);
            per = ref_period(sel);
            speed_sel = 2'(sel);
            tick(3);
            e0 = edge_n;
            run_sw = 1'b1;
            e_run = e0 + Db + 3;
            tick_to(e_run - 1);
            checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_early: got %b want 0", running); end
            tick_to(e_run);
            checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_entry: got %b want 1", running); end
            n = $urandom_range(2, 5);
            last = e_run + per * n;
            tick_to(last + 1);
            checks++; if (en_q.size() != n) begin errors++; $display("FAIL run_pulses sel=%0d: got %0d want %0d", sel, en_q.size(), n); end
            for (int k = 0; k < int'(n) && k < en_q.size(); k++) begin
                got = en_q[k];
                checks++;
                if (got != e_run + per * (k + 1)) begin
                    errors++;
                    $display("FAIL run_pulse_time sel=%0d k=%0d: got %0d want %0d", sel, k, got - e_run, per * (k + 1));
                end
            end
            checks++;
            if (step_count !== 8'((edge_n - e_run) / per)) begin
                errors++;
                $display("FAIL run_count: got %0d want %0d", step_count, (edge_n - e_run) / per);
            end
        end
    endtask

    task automatic test_speed_change_wrap;
        int unsigned e0, e_run, p, m, t, ts, total, n, got;
        do_reset();
        speed_sel = 2'd2;
        tick(3);
        e0 = edge_n;
        run_sw = 1'b1;
        e_run = e0 + Db + 3;
        p = e_run + ref_period(2);
        m = $urandom_range(1, 5);
        tick_to(p + m);
        t = edge_n;
        speed_sel = 2'd3;
        tick_to(t + 4 + 262);
        ts = edge_n;
        run_sw = 1'b0;
        tick_to(ts + Db + 10);
        // One pulse at the old rate, then continuous from one period after the restart
        // until the debounced switch drops.
        total = 1 + ((ts + Db + 2) - (t + 4) + 1);
        n = en_q.size();
        checks++; if (n != total) begin errors++; $display("FAIL spd_pulses: got %0d want %0d", n, total); end
        got = (n > 0) ? en_q[0] : 0;
        checks++; if (got != p) begin errors++; $display("FAIL spd_first: got %0d want %0d", got, p); end
        got = (n > 1) ? en_q[1] : 0;
        checks++; if (got != t + 4) begin errors++; $display("FAIL spd_restart: got %0d want %0d", got, t + 4); end
        got = (n > 0) ? en_q[n - 1] : 0;
        checks++; if (got != ts + Db + 2) begin errors++; $display("FAIL spd_last: got %0d want %0d", got, ts + Db + 2); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL spd_exit: got %b want 0", running); end
        checks++; if (step_count !== 8'(total)) begin errors++; $display("FAIL wrap_count: got %0d want %0d", step_count, total % 256); end
    endtask

    task automatic test_halt_lock;
        int unsigned e0, e_run, k, term, e1;
        do_reset();
        speed_sel = 2'd2;
        tick(3);
        e0 = edge_n;
        run_sw = 1'b1;
        e_run = e0 + Db + 3;
        k = $urandom_range(1, 3);
        term = e_run + ref_period(2) * k;
        tick_to(term - 1);
        cpu_halt = 1'b1;
        tick_to(term + 1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_exit: got %b want 0", running); end
        checks++; if (en_q.size() != k - 1) begin errors++; $display("FAIL halt_no_pulse: got %0d want %0d", en_q.size(), k - 1); end
        step_btn = 1'b1;
        tick(Db + 10);
        checks++; if (en_q.size() != k - 1) begin errors++; $display("FAIL halt_step_ignored: got %0d want %0d", en_q.size(), k - 1); end
        step_btn = 1'b0;
        tick(Db + 6);
        cpu_halt = 1'b0;
        tick(20);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_lock_held: got %b want 0", running); end
        checks++; if (step_count !== 8'(k - 1)) begin errors++; $display("FAIL halt_count: got %0d want %0d", step_count, k - 1); end
        run_sw = 1'b0;
        tick(Db + 6);
        e1 = edge_n;
        run_sw = 1'b1;
        tick_to(e1 + Db + 2);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", running); end
        tick_to(e1 + Db + 3);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL relock_entry: got %b want 1", running); end
    endtask

    task automatic test_step_in_run;
        int unsigned e0, e_run, ts, n, got;
        do_reset();
        speed_sel = 2'd2;
        tick(3);
        e0 = edge_n;
        run_sw = 1'b1;
        e_run = e0 + Db + 3;
        tick_to(e_run + $urandom_range(1, 8));
        step_btn = 1'b1;
        tick_to(e_run + 45);
        ts = edge_n;
        run_sw = 1'b0;
        tick_to(ts + Db + 30);
        n = (ts + Db + 2 - e_run) / ref_period(2);
        checks++; if (en_q.size() != n) begin errors++; $display("FAIL sir_pulses: got %0d want %0d", en_q.size(), n); end
        for (int k = 0; k < int'(n) && k < en_q.size(); k++) begin
            got = en_q[k];
            checks++;
            if (got != e_run + ref_period(2) * (k + 1)) begin
                errors++;
                $display("FAIL sir_pulse_time k=%0d: got %0d want %0d", k, got, e_run + ref_period(2) * (k + 1));
            end
        end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL sir_exit: got %b want 0", running); end
        step_btn = 1'b0;
        tick(Db + 6);
        checks++; if (step_count !== 8'(n)) begin errors++; $display("FAIL sir_count: got %0d want %0d", step_count, n); end
    endtask

    task automatic test_reset_mid_run;
        int unsigned e0, e_run, r, got;
        do_reset();
        speed_sel = 2'd3;
        tick(3);
        e0 = edge_n;
        run_sw = 1'b1;
        e_run = e0 + Db + 3;
        tick_to(e_run + 20);
        #3;
        n_reset = 1'b0;
        #1;
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL midrst_cpu_en: got %b want 0", cpu_en); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrst_running: got %b want 0", running); end
        checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", step_count); end
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        en_q.delete();
        r = edge_n;
        tick_to(r + Db + 2);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrst_early: got %b want 0", running); end
        checks++; if (en_q.size() != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d want 0", en_q.size()); end
        tick_to(r + Db + 3);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL midrst_reentry: got %b want 1", running); end
        tick_to(r + Db + 6);
        got = (en_q.size() > 0) ? en_q[0] : 0;
        checks++; if (got != r + Db + 4) begin errors++; $display("FAIL midrst_first: got %0d want %0d", got, r + Db + 4); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_bounce();
        test_run();
        test_speed_change_wrap();
        test_halt_lock();
        test_step_in_run();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1);
    end

endmodule
